dekatron_counter_ctrl: RTL and testbench

Sequencer for a chain of DIGITS dekatron digit cells forming a decimal up/down counter. Accepts increment, decrement, load and clear requests over a req/ack handshake. Drives each digit's PulseRight/PulseLeft/Set lines in order, waits for the digit's Ready, and propagates carry or borrow from least- to most-significant digit. Sits between the DPC control unit and the dekatron register digits (IP, AP, loop counters).

---
 rtl/dekatron_pkg.sv | 38 +++
 rtl/dekatron_pulse_timer.sv | 45 ++++
 rtl/dekatron_counter_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_dekatron_counter_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pkg.sv
// Shared definitions for the dekatron counter sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: request opcode encodings, the sequencer state enum, and the
// BCD-to-one-hot helper used to build dekatron write values.
package dekatron_pkg;

    // ReqOp encodings
    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PULSE,
        ST_WAIT,
        ST_NEXT,
        ST_LOAD,
        ST_LWAIT,
        ST_DONE
    } state_t;

    // One-hot cathode pattern for a BCD digit; invalid codes (>9) map to 0.
    function automatic logic [9:0] bcd_to_onehot(input logic [3:0] bcd);
        logic [9:0] oh;
        oh = 10'd0;
        if (bcd <= 4'd9) begin
            oh = 10'd1 << bcd;
        end else begin
            oh = 10'd1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/dekatron_pulse_timer.sv
// Loadable down-counter timing step-pulse width and the Ready timeout.
// Latency: load takes effect next edge; done is a combinational decode of the count.
// Backpressure: none; i_en simply pauses the count.
//
// Ports:
//   hsClk, Rst_n     clock and synchronous active-low reset
//   i_load           load i_load_val (wins over i_en)
//   i_load_val       start value; the counter stops at 0
//   i_load_tmo       tags the loaded count as a timeout count
//   i_en             decrement enable
//   o_done           count is 0
//   o_timeout        count is 0 and was loaded as a timeout (only when TMO_EN)
module dekatron_pulse_timer #(
    parameter int W      = 8,
    parameter bit TMO_EN = 1'b0
) (
    input  logic         hsClk,
    input  logic         Rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_load_tmo,
    input  logic         i_en,
    output logic         o_done,
    output logic         o_timeout
);

    logic [W-1:0] r_cnt;
    logic         r_tmo_mode;

    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            r_cnt      <= '0;
            r_tmo_mode <= 1'b0;
        end else if (i_load) begin
            r_cnt      <= i_load_val;
            r_tmo_mode <= i_load_tmo;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done    = (r_cnt == '0);
    assign o_timeout = TMO_EN && r_tmo_mode && o_done;

endmodule

// File: rtl/dekatron_counter_ctrl.sv
// Sequencer driving a chain of dekatron digits as a decimal up/down counter.
// Latency: inc/dec k digits -> Ack at t0 + k*(PULSE_CYCLES+3) + 1; load/clear -> Ack at t0+3 min.
// Backpressure: Req only sampled in IDLE; waits on per-digit DigitReady (optional timeout).
//
// Optional feature macro: DEKATRON_CTRL_TIMEOUT_EN (WAIT/LWAIT timeout setting Error).
// Ports:
//   hsClk, Rst_n            clock, synchronous active-low reset
//   Req, ReqOp, LoadData    request level, opcode, BCD load value (digit d at [4d+3:4d])
//   Ack, Busy               one-cycle completion pulse, not-IDLE flag
//   DigitOut, DigitReady    one-hot cathode state and Ready from each digit
//   PulseRight, PulseLeft   per-digit increment / decrement step pulses
//   Set, DigitIn            per-digit write strobe and one-hot write value
//   Wrap, Error             sticky: chain wrapped / Ready timeout on the last op
module dekatron_counter_ctrl
    import dekatron_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int PULSE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 hsClk,
    input  logic                 Rst_n,
    input  logic                 Req,
    input  logic [1:0]           ReqOp,
    input  logic [4*DIGITS-1:0]  LoadData,
    output logic                 Ack,
    output logic                 Busy,
    input  logic [10*DIGITS-1:0] DigitOut,
    input  logic [DIGITS-1:0]    DigitReady,
    output logic [DIGITS-1:0]    PulseRight,
    output logic [DIGITS-1:0]    PulseLeft,
    output logic [DIGITS-1:0]    Set,
    output logic [10*DIGITS-1:0] DigitIn,
    output logic                 Wrap,
    output logic                 Error
);

`ifdef DEKATRON_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAXC  = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [DW-1:0] LAST_D = DW'(DIGITS - 1);

    state_t                r_state;
    state_t                w_nxt_state;
    logic [1:0]            r_op;
    logic [4*DIGITS-1:0]   r_load_dat;
    logic [DW-1:0]         r_d;
    logic                  r_carry;
    logic                  r_wrap;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_d_inc;
    logic                  w_set_wrap;
    logic                  w_set_error;
    logic                  w_tmr_load;
    logic                  w_tmr_load_tmo;
    logic [CNT_W-1:0]      w_tmr_val;
    logic                  w_tmr_en;
    logic                  w_tmr_done;
    logic                  w_tmr_tmo;

    logic [DIGITS-1:0]     w_dig_oh;
    logic [9:0]            w_cur_dout;
    logic                  w_cur_rdy;
    logic [10*DIGITS-1:0]  w_load_oh;

    // Select the digit currently being stepped.
    always_comb begin
        w_dig_oh   = '0;
        w_cur_dout = '0;
        w_cur_rdy  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_d == DW'(i)) begin
                w_dig_oh[i] = 1'b1;
                w_cur_dout  = DigitOut[10*i +: 10];
                w_cur_rdy   = DigitReady[i];
            end
        end
    end

    // Write values for LOAD; clear writes digit value 0 everywhere.
    always_comb begin
        w_load_oh = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_oh[10*i +: 10] = (r_op == OP_LOAD) ? bcd_to_onehot(r_load_dat[4*i +: 4])
                                                      : bcd_to_onehot(4'd0);
        end
    end

    dekatron_pulse_timer #(
        .W      (CNT_W),
        .TMO_EN (TMO_EN)
    ) u_timer (
        .hsClk      (hsClk),
        .Rst_n      (Rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_load_tmo (w_tmr_load_tmo),
        .i_en       (w_tmr_en),
        .o_done     (w_tmr_done),
        .o_timeout  (w_tmr_tmo)
    );

    // State register.
    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_nxt_state    = r_state;
        w_accept       = 1'b0;
        w_d_inc        = 1'b0;
        w_set_wrap     = 1'b0;
        w_set_error    = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_load_tmo = 1'b0;
        w_tmr_val      = '0;
        w_tmr_en       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req) begin
                    w_accept    = 1'b1;
                    w_nxt_state = ((ReqOp == OP_INC) || (ReqOp == OP_DEC)) ? ST_CHECK : ST_LOAD;
                end
            end
            ST_CHECK: begin
                // Count PULSE_CYCLES-1 down to 0: PULSE lasts PULSE_CYCLES cycles.
                w_tmr_load  = 1'b1;
                w_tmr_val   = CNT_W'(PULSE_CYCLES - 1);
                w_nxt_state = ST_PULSE;
            end
            ST_PULSE: begin
                if (w_tmr_done) begin
                    // Arm the timeout so it expires on the TIMEOUT_CYCLES-th WAIT cycle.
                    w_tmr_load     = TMO_EN;
                    w_tmr_load_tmo = TMO_EN;
                    w_tmr_val      = CNT_W'(TIMEOUT_CYCLES - 1);
                    w_nxt_state    = ST_WAIT;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_WAIT: begin
                w_tmr_en = TMO_EN;
                if (w_cur_rdy) begin
                    w_nxt_state = ST_NEXT;
                end else if (w_tmr_tmo) begin
                    // Timeout abandons the rest of the carry chain.
                    w_set_error = 1'b1;
                    w_nxt_state = ST_DONE;
                end
            end
            ST_NEXT: begin
                if (r_carry && (r_d != LAST_D)) begin
                    w_d_inc     = 1'b1;
                    w_nxt_state = ST_CHECK;
                end else begin
                    w_set_wrap  = r_carry;
                    w_nxt_state = ST_DONE;
                end
            end
            ST_LOAD: begin
                w_tmr_load     = TMO_EN;
                w_tmr_load_tmo = TMO_EN;
                w_tmr_val      = CNT_W'(TIMEOUT_CYCLES - 1);
                w_nxt_state    = ST_LWAIT;
            end
            ST_LWAIT: begin
                w_tmr_en = TMO_EN;
                if (&DigitReady) begin
                    w_nxt_state = ST_DONE;
                end else if (w_tmr_tmo) begin
                    w_set_error = 1'b1;
                    w_nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Request latches, digit index, carry and sticky flags.
    always_ff @(posedge hsClk) begin
        if (!Rst_n) begin
            r_op       <= OP_INC;
            r_load_dat <= '0;
            r_d        <= '0;
            r_carry    <= 1'b0;
            r_wrap     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op       <= ReqOp;
                r_load_dat <= LoadData;
                r_d        <= '0;
                r_wrap     <= 1'b0;
                r_error    <= 1'b0;
            end
            // A digit at 9 (inc) or 0 (dec) before stepping produces carry/borrow.
            if (r_state == ST_CHECK) begin
                r_carry <= (r_op == OP_INC) ? w_cur_dout[9] : w_cur_dout[0];
            end
            if (w_d_inc) begin
                r_d <= r_d + DW'(1);
            end
            if (w_set_wrap) begin
                r_wrap <= 1'b1;
            end
            if (TMO_EN && w_set_error) begin
                r_error <= 1'b1;
            end
        end
    end

    // Outputs decode from registered state, so reset clears them on the next edge.
    assign Busy       = (r_state != ST_IDLE);
    assign Ack        = (r_state == ST_DONE);
    assign PulseRight = ((r_state == ST_PULSE) && (r_op == OP_INC)) ? w_dig_oh : '0;
    assign PulseLeft  = ((r_state == ST_PULSE) && (r_op == OP_DEC)) ? w_dig_oh : '0;
    assign Set        = (r_state == ST_LOAD) ? {DIGITS{1'b1}} : '0;
    assign DigitIn    = (r_state == ST_LOAD) ? w_load_oh : '0;
    assign Wrap       = r_wrap;
    assign Error      = r_error;

endmodule

// File: tb/tb_dekatron_counter_ctrl.sv
module tb_dekatron_counter_ctrl;
    import dekatron_pkg::*;

    localparam int N = 3;

    logic          hsClk = 1'b0;
    logic          Rst_n = 1'b0;
    logic          Req = 1'b0;
    logic [1:0]    ReqOp = 2'b00;
    logic [4*N-1:0] LoadData = '0;
    logic          Ack, Busy, Wrap, Error;
    logic [10*N-1:0] DigitOut, DigitIn;
    logic [N-1:0]  DigitReady, PulseRight, PulseLeft, Set;

    always #5 hsClk = ~hsClk;

    dekatron_counter_ctrl #(.DIGITS(N), .PULSE_CYCLES(2), .TIMEOUT_CYCLES(64)) dut (
        .hsClk(hsClk), .Rst_n(Rst_n), .Req(Req), .ReqOp(ReqOp), .LoadData(LoadData),
        .Ack(Ack), .Busy(Busy), .DigitOut(DigitOut), .DigitReady(DigitReady),
        .PulseRight(PulseRight), .PulseLeft(PulseLeft), .Set(Set), .DigitIn(DigitIn),
        .Wrap(Wrap), .Error(Error)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge hsClk) cyc <= cyc + 1;

    // Dekatron digit model: steps on the rising edge of a pulse, loads on Set.
    int dval[N];
    logic [N-1:0] rdy_low = '0;
    logic [N-1:0] pr_q = '0, pl_q = '0;
    int pr_cnt[N], pl_cnt[N];
    int set_cnt = 0;
    logic [10*N-1:0] cap_din = '0;
    int order_q[$];

    function automatic int oh2int(input logic [9:0] oh);
        int v;
        v = 0;
        for (int b = 0; b < 10; b++) if (oh[b]) v = b;
        return v;
    endfunction

    function automatic int cur_value();
        return dval[2] * 100 + dval[1] * 10 + dval[0];
    endfunction

    always @(negedge hsClk) begin
        for (int d = 0; d < N; d++) begin
            if (Set[d]) dval[d] = oh2int(DigitIn[10*d +: 10]);
            else if (PulseRight[d] && !pr_q[d]) begin dval[d] = (dval[d] + 1) % 10; order_q.push_back(d); end
            else if (PulseLeft[d] && !pl_q[d]) begin dval[d] = (dval[d] + 9) % 10; order_q.push_back(d); end
            if (PulseRight[d]) pr_cnt[d]++;
            if (PulseLeft[d]) pl_cnt[d]++;
        end
        if (Set != '0) begin set_cnt++; cap_din = DigitIn; end
        pr_q = PulseRight;
        pl_q = PulseLeft;
    end

    always_comb begin
        DigitOut = '0;
        for (int d = 0; d < N; d++) DigitOut[10*d +: 10] = 10'd1 << dval[d];
    end
    assign DigitReady = ~rdy_low;

    // Scoreboard: expected completions pushed at issue, popped on Ack.
    typedef struct {
        int   ack_cyc;
        int   value;
        logic wrap;
        logic err;
    } exp_t;
    exp_t sb[$];

    always @(negedge hsClk) begin
        if (Ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.ack_cyc);
                chk("value", cur_value(), e.value);
                chk("wrap", Wrap, e.wrap);
                chk("error", Error, e.err);
            end
        end
    end

    task automatic clear_stats();
        for (int d = 0; d < N; d++) begin pr_cnt[d] = 0; pl_cnt[d] = 0; end
        set_cnt = 0;
        order_q.delete();
    endtask

    // Issue one request, push its expected completion, wait for Ack (bounded).
    task automatic issue(input logic [1:0] op, input logic [11:0] ld, input int lat,
                         input int value, input logic wrap, input logic err);
        exp_t e;
        bit got;
        @(negedge hsClk);
        clear_stats();
        Req = 1'b1; ReqOp = op; LoadData = ld;
        @(posedge hsClk); #1;
        e.ack_cyc = cyc + lat - 1;
        e.value = value; e.wrap = wrap; e.err = err;
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge hsClk);
            if (Ack) begin got = 1; break; end
        end
        if (!got) chk("ack_wait", 0, 1);
        Req = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < N; d++) dval[d] = 0;
        repeat (3) @(negedge hsClk);
        chk("rst_pulse_r", PulseRight, 0);
        chk("rst_pulse_l", PulseLeft, 0);
        chk("rst_set", Set, 0);
        chk("rst_digit_in", DigitIn, 0);
        chk("rst_ack", Ack, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_wrap", Wrap, 0);
        chk("rst_error", Error, 0);
        Rst_n = 1'b1;

        // Load 0x3A7: nibble A loads 0 -> 307
        issue(OP_LOAD, 12'h3A7, 3, 307, 1'b0, 1'b0);
        chk("load_set_cycles", set_cnt, 1);
        chk("load_digit_in", cap_din, {10'b0000001000, 10'b0000000001, 10'b0010000000});

        // 005 + 1
        issue(OP_LOAD, 12'h005, 3, 5, 1'b0, 1'b0);
        issue(OP_INC, 12'h000, 6, 6, 1'b0, 1'b0);
        chk("inc_pr0_width", pr_cnt[0], 2);
        chk("inc_other_pulses", pr_cnt[1] + pr_cnt[2] + pl_cnt[0] + pl_cnt[1] + pl_cnt[2], 0);

        // 099 + 1 ripples through all three digits
        issue(OP_LOAD, 12'h099, 3, 99, 1'b0, 1'b0);
        issue(OP_INC, 12'h000, 16, 100, 1'b0, 1'b0);
        chk("ripple_steps", order_q.size(), 3);
        if (order_q.size() == 3) chk("ripple_order", order_q[0] * 100 + order_q[1] * 10 + order_q[2], 12);

        // clear, then 000 - 1 -> 999 with wrap
        issue(OP_CLR, 12'h555, 3, 0, 1'b0, 1'b0);
        issue(OP_DEC, 12'h000, 16, 999, 1'b1, 1'b0);
        chk("dec_pl_total", pl_cnt[0] + pl_cnt[1] + pl_cnt[2], 6);
        chk("dec_pr_total", pr_cnt[0] + pr_cnt[1] + pr_cnt[2], 0);
        repeat (4) @(negedge hsClk);
        chk("wrap_sticky", Wrap, 1);

        // 999 + 1 -> 000 with carry out of the MSD
        issue(OP_INC, 12'h000, 16, 0, 1'b1, 1'b0);
        // new request clears wrap
        issue(OP_LOAD, 12'h009, 3, 9, 1'b0, 1'b0);

        // Ready stuck low on digit 0 after its step
        rdy_low = 3'b001;
`ifdef DEKATRON_CTRL_TIMEOUT_EN
        // WAIT entry at t0+4, timeout Ack 64 cycles later; carry to digit 1 suppressed
        issue(OP_INC, 12'h000, 68, 0, 1'b0, 1'b1);
        rdy_low = '0;
        issue(OP_LOAD, 12'h123, 3, 123, 1'b0, 1'b0);
`else
        begin
            bit ack_seen;
            ack_seen = 0;
            @(negedge hsClk);
            Req = 1'b1; ReqOp = OP_INC;
            for (int i = 0; i < 120; i++) begin
                @(negedge hsClk);
                if (Ack) ack_seen = 1;
            end
            chk("stall_no_ack", ack_seen, 0);
            chk("stall_busy", Busy, 1);
            chk("stall_error", Error, 0);
            Req = 1'b0; Rst_n = 1'b0; rdy_low = '0;
            @(posedge hsClk); #1;
            chk("stall_rst_busy", Busy, 0);
            @(negedge hsClk);
            Rst_n = 1'b1;
            issue(OP_LOAD, 12'h123, 3, 123, 1'b0, 1'b0);
        end
`endif
        rdy_low = '0;

        // Reset during digit-1 pulse of 099+1
        issue(OP_LOAD, 12'h099, 3, 99, 1'b0, 1'b0);
        begin
            bit seen;
            seen = 0;
            @(negedge hsClk);
            Req = 1'b1; ReqOp = OP_INC;
            for (int i = 0; i < 50; i++) begin
                @(negedge hsClk);
                if (PulseRight[1]) begin seen = 1; break; end
            end
            chk("mid_pulse_reached", seen, 1);
            Rst_n = 1'b0; Req = 1'b0;
            @(posedge hsClk); #1;
            chk("midrst_pulse_r", PulseRight, 0);
            chk("midrst_pulse_l", PulseLeft, 0);
            chk("midrst_set", Set, 0);
            chk("midrst_ack", Ack, 0);
            chk("midrst_busy", Busy, 0);
            chk("midrst_wrap", Wrap, 0);
            repeat (2) @(negedge hsClk);
            Rst_n = 1'b1;
        end
        // digit 1 was already stepped 9->0 before reset: value now 000
        issue(OP_INC, 12'h000, 6, 1, 1'b0, 1'b0);

        repeat (5) @(negedge hsClk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
